dmem_byte_sequencer: RTL and testbench
======================================

# dmem_byte_sequencer

Multi-cycle bridge between the processor datapath's data-memory port (ALU result address, store data, access-size selector) and a byte-wide synchronous RAM. It splits word and halfword loads/stores into sequential byte transfers on the RAM port, returns the assembled little-endian load value, and holds the core with `Stall` until the access completes. It sits directly downstream of the datapath, in place of a word-wide data memory.

## Interface
Parameters:
- `ADDR_W`, 16, width of the byte address on the RAM port; `Addr[31:ADDR_W]` is ignored.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `MemWrite`  in  1  store request.
- `MemRead`  in  1  load request.
- `Addr`  in  32  byte address from the datapath ALU result.
- `WriteData`  in  32  store data.
- `MemorySelector`  in  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
- `ReadData`  out  32  assembled load value, zero-extended.
- `Stall`  out  1  high while a requested access is not yet complete; the core freezes the PC and holds all inputs stable.
- `Misalign`  out  1  one-cycle pulse when an accepted request has address bits below its size alignment set.
- `ram_addr`  out  ADDR_W  RAM byte address.
- `ram_wdata`  out  8  RAM write byte.
- `ram_we`  out  1  RAM write enable.
- `ram_rdata`  in  8  RAM read byte, valid one cycle after `ram_addr` is presented (registered-output RAM).

## Operation
- Request `req = MemRead | MemWrite`. If both are high, the access is a write and the read is ignored.
- N = 4 for word, 2 for halfword, 1 for byte.
- Base address = `Addr[ADDR_W-1:0]`, with the low 2 bits cleared for word and bit 0 cleared for halfword. Misaligned low bits are dropped and `Misalign` pulses.
- Little-endian: byte k is at `base+k` and maps to data bits `[8k+7:8k]`.
- FSM states: IDLE, XFER, DONE.
  - IDLE: when `req` is high, latch write/read, N, base and `WriteData`, clear counter `cnt`, and go to XFER. `Stall=1` in that cycle. Otherwise stay in IDLE with `Stall=0`.
  - XFER (`Stall=1`):
    - If `cnt < N`: drive `ram_addr = base + cnt`. For a write, also drive `ram_we=1` and `ram_wdata` = latched byte `cnt`.
    - For a read with `cnt >= 1`: capture `ram_rdata` into assembly byte `cnt-1`.
    - A write leaves for DONE after issuing byte N-1. A read leaves for DONE after capturing byte N-1 at `cnt == N`.
    - `cnt` increments every XFER cycle.
  - DONE (`Stall=0`): for a read, `ReadData` shows the assembled value with unused upper bytes set to zero. Next state is always IDLE. A request present in DONE is not restarted, because it belongs to the instruction retiring on this edge.
- `ReadData` holds its value until the next read reaches DONE. Writes do not change it.
- `ram_addr` arithmetic is modulo 2^ADDR_W. Alignment guarantees that no access crosses the top of the address space.
- Outside XFER: `ram_we=0`, `ram_addr` = last driven value, `ram_wdata=0`.

## Timing
- Reset values: state IDLE, `cnt=0`, `ReadData=0`, `ram_addr=0`, `ram_wdata=0`, `ram_we=0`, `Misalign=0`.
- While `reset` is high, `Stall=0` and `ram_we=0` (combinational gating).
- Store latency: `Stall` is high for 1+N cycles, followed by 1 DONE cycle.
- Load latency: `Stall` is high for 2+N cycles, followed by 1 DONE cycle. The word load totals 7 cycles from request to the retiring edge.
- `Stall` is combinational from the state and `req`. It rises in the same cycle the request appears in IDLE.
- `Misalign` is registered and is high during the first XFER cycle.
- Reset mid-access: at the next edge, return to IDLE. Any partial store remains in RAM and is not rolled back. The partial load is discarded and `ReadData=0`.
- Request dropped by the core during XFER is illegal. The block completes the latched access regardless.

## Test plan
- Word store of 0xDEADBEEF to `Addr=0x0100`, selector 00:
  - RAM writes 0xEF@0x100, 0xBE@0x101, 0xAD@0x102, 0xDE@0x103 on consecutive cycles.
  - `Stall` is high for 5 cycles, then low for 1.
- Word load from 0x0100 after the store: `ReadData=0xDEADBEEF` in DONE, and `Stall` is high for exactly 6 cycles.
- Halfword load from 0x0102 returns 0x0000DEAD. Byte load from 0x0101 returns 0x000000BE. Byte store of 0x77 to 0x0103, then a word load from 0x0100, returns 0x77ADBEEF.
- Misaligned word load at `Addr=0x0103`:
  - Accesses bytes 0x100–0x103.
  - `Misalign` pulses once.
  - Returns 0x77ADBEEF.
- `MemRead` and `MemWrite` high together with data 0x11223344 at 0x0200: a word write occurs, and `ReadData` is unchanged from its prior value.
- Reset asserted on the 3rd XFER cycle of a word store of 0xAABBCCDD to 0x0300:
  - Next cycle: IDLE, `Stall=0`, `ram_we=0`.
  - RAM holds 0xDD, 0xCC at 0x300–0x301 and is untouched at 0x302–0x303.

Source files
------------

// File: rtl/dmem_byte_sequencer.sv
// Bridges the word-wide datapath memory port onto a byte-wide registered-output RAM,
// serialising word/halfword accesses into byte transfers and stalling the core until done.
module dmem_byte_sequencer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WriteData,
  input  logic [1:0]        MemorySelector,
  output logic [31:0]       ReadData,
  output logic              Stall,
  output logic              Misalign,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic              wr_q, wr_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              req;
  logic [2:0]        req_n;
  logic [ADDR_W-1:0] req_base;
  logic              req_mis;
  logic [1:0]        rd_idx;
  logic [7:0]        wbyte;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^Addr[31:ADDR_W];

  // Request decode: size, aligned base and misalignment flag.
  always_comb begin
    req      = MemRead | MemWrite;
    req_base = Addr[ADDR_W-1:0];
    req_n    = 3'd4;
    req_mis  = 1'b0;
    case (MemorySelector)
      2'b01: begin
        req_n       = 3'd2;
        req_base[0] = 1'b0;
        req_mis     = Addr[0];
      end
      2'b10: begin
        req_n   = 3'd1;
        req_mis = 1'b0;
      end
      default: begin
        req_n         = 3'd4;
        req_base[1:0] = 2'b00;
        req_mis       = |Addr[1:0];
      end
    endcase
  end

  // Read data for byte cnt-1 arrives the cycle after its address; cnt==4 wraps to index 3.
  assign rd_idx = cnt_q[1:0] - 2'd1;
  assign wbyte  = wdata_q[{cnt_q[1:0], 3'b000} +: 8];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    wr_d       = wr_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    rdata_d    = rdata_q;
    ram_addr_d = ram_addr_q;
    misalign_d = 1'b0;
    ram_addr   = ram_addr_q;
    ram_wdata  = 8'h00;
    ram_we     = 1'b0;
    Stall      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          Stall      = 1'b1;
          wr_d       = MemWrite;
          n_d        = req_n;
          base_d     = req_base;
          wdata_d    = WriteData;
          cnt_d      = 3'd0;
          asm_d      = 32'h0;
          misalign_d = req_mis;
          state_d    = XFER;
        end
      end
      XFER: begin
        Stall = 1'b1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q < n_q) begin
          ram_addr_d = base_q + ADDR_W'(cnt_q);
          ram_addr   = ram_addr_d;
          if (wr_q) begin
            ram_we    = 1'b1;
            ram_wdata = wbyte;
          end
        end
        if (!wr_q && cnt_q != 3'd0) begin
          asm_d[{rd_idx, 3'b000} +: 8] = ram_rdata;
        end
        if (wr_q ? (cnt_q == n_q - 3'd1) : (cnt_q == n_q)) begin
          state_d = DONE;
          if (!wr_q) begin
            rdata_d = asm_d;
          end
        end
      end
      DONE: begin
        // A request still present here belongs to the retiring instruction.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      Stall  = 1'b0;
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      n_q        <= 3'd0;
      wr_q       <= 1'b0;
      base_q     <= '0;
      wdata_q    <= 32'h0;
      asm_q      <= 32'h0;
      rdata_q    <= 32'h0;
      ram_addr_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      wr_q       <= wr_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      rdata_q    <= rdata_d;
      ram_addr_q <= ram_addr_d;
      misalign_q <= misalign_d;
    end
  end

  assign ReadData = rdata_q;
  assign Misalign = misalign_q;

endmodule

// File: tb/tb_dmem_byte_sequencer.sv
// Directed bench for dmem_byte_sequencer with a behavioural registered-output byte RAM.
module tb_dmem_byte_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead;
  logic [31:0] Addr, WriteData;
  logic [1:0]  MemorySelector;
  logic [31:0] ReadData;
  logic        Stall, Misalign;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  logic [7:0]  mem [0:65535];

  int checks = 0;
  int errors = 0;

  int          stalls, mis, nwr;
  logic [31:0] rdv;
  logic [15:0] wr_a [0:23];
  logic [7:0]  wr_b [0:23];
  int          wr_at [0:23];
  logic [15:0] acc_a [0:23];

  dmem_byte_sequencer #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Addr(Addr), .WriteData(WriteData), .MemorySelector(MemorySelector),
    .ReadData(ReadData), .Stall(Stall), .Misalign(Misalign),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  // Called one step after a rising edge; returns one step after the edge that enters IDLE again.
  task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sel);
    MemWrite = wr; MemRead = rd; Addr = a; WriteData = wd; MemorySelector = sel;
    #1;
    stalls = 0; mis = 0; nwr = 0;
    while (Stall === 1'b1 && stalls < 20) begin
      if (Misalign) mis++;
      if (ram_we) begin
        wr_a[nwr] = ram_addr; wr_b[nwr] = ram_wdata; wr_at[nwr] = stalls; nwr++;
      end
      acc_a[stalls] = ram_addr;
      stalls++;
      @(posedge clk); #2;
    end
    rdv = ReadData;
    MemWrite = 1'b0; MemRead = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
    Addr = 32'h0; WriteData = 32'h0; MemorySelector = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_readdata", ReadData, 32'h0);
    check("rst_stall", {31'b0, Stall}, 32'h0);
    check("rst_we", {31'b0, ram_we}, 32'h0);
    check("rst_addr", {16'b0, ram_addr}, 32'h0);
    check("rst_wdata", {24'b0, ram_wdata}, 32'h0);
    check("rst_misalign", {31'b0, Misalign}, 32'h0);
    @(posedge clk); #1;

    // Word store, bytes issued on consecutive stall cycles 1..4
    access(1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 2'b00);
    check("sw_stalls", stalls, 5);
    check("sw_nwr", nwr, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sw_wr%0d", k), {wr_at[k][7:0], wr_a[k], wr_b[k]},
            {8'(k + 1), 16'(16'h0100 + k), 8'(32'hDEAD_BEEF >> (8 * k))});
    end
    check("sw_mem", mem_word(16'h0100), 32'hDEAD_BEEF);
    check("sw_misalign", mis, 0);

    access(1'b0, 1'b1, 32'h0000_0100, 32'h0, 2'b00);
    check("lw_stalls", stalls, 6);
    check("lw_data", rdv, 32'hDEAD_BEEF);

    access(1'b0, 1'b1, 32'h0000_0102, 32'h0, 2'b01);
    check("lh_stalls", stalls, 4);
    check("lh_data", rdv, 32'h0000_DEAD);

    access(1'b0, 1'b1, 32'h0000_0101, 32'h0, 2'b10);
    check("lb_stalls", stalls, 3);
    check("lb_data", rdv, 32'h0000_00BE);

    access(1'b1, 1'b0, 32'h0000_0103, 32'h0000_0077, 2'b10);
    check("sb_stalls", stalls, 2);
    check("sb_nwr", nwr, 1);
    check("sb_wr0", {wr_a[0], wr_b[0]}, {16'h0103, 8'h77});
    check("sb_readdata_kept", rdv, 32'h0000_00BE);

    access(1'b0, 1'b1, 32'h0000_0100, 32'h0, 2'b00);
    check("lw2_data", rdv, 32'h77AD_BEEF);

    access(1'b0, 1'b1, 32'h0000_0103, 32'h0, 2'b00);
    check("mis_pulses", mis, 1);
    check("mis_stalls", stalls, 6);
    for (int k = 0; k < 4; k++)
      check($sformatf("mis_addr%0d", k), {16'b0, acc_a[k + 1]}, 32'(16'h0100 + k));
    check("mis_data", rdv, 32'h77AD_BEEF);
    check("mis_idle_misalign", {31'b0, Misalign}, 32'h0);

    access(1'b0, 1'b1, 32'h0000_0101, 32'h0, 2'b01);
    check("mis_half_pulses", mis, 1);
    check("mis_half_data", rdv, 32'h0000_BEEF);

    // Selector 11 behaves as word
    access(1'b0, 1'b1, 32'h0000_0100, 32'h0, 2'b11);
    check("sel11_data", rdv, 32'h77AD_BEEF);

    access(1'b1, 1'b1, 32'h0000_0200, 32'h1122_3344, 2'b00);
    check("both_stalls", stalls, 5);
    check("both_nwr", nwr, 4);
    check("both_mem", mem_word(16'h0200), 32'h1122_3344);
    check("both_readdata_kept", ReadData, 32'h77AD_BEEF);

    // Reset during the third XFER cycle of a word store
    MemWrite = 1'b1; MemRead = 1'b0; Addr = 32'h0000_0300;
    WriteData = 32'hAABB_CCDD; MemorySelector = 2'b00;
    #1;
    repeat (3) begin @(posedge clk); #2; end
    reset = 1'b1;
    #1;
    check("rstx_stall_gated", {31'b0, Stall}, 32'h0);
    check("rstx_we_gated", {31'b0, ram_we}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; MemWrite = 1'b0;
    #1;
    check("rstx_stall", {31'b0, Stall}, 32'h0);
    check("rstx_we", {31'b0, ram_we}, 32'h0);
    check("rstx_readdata", ReadData, 32'h0);
    check("rstx_mem", mem_word(16'h0300), 32'h0000_CCDD);
    @(posedge clk); #1;

    access(1'b0, 1'b1, 32'h0000_0301, 32'h0, 2'b10);
    check("post_rst_stalls", stalls, 3);
    check("post_rst_data", rdv, 32'h0000_00CC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
